vec_load16: RTL and testbench

VEC_LOAD16 -- requirements
Module: vec_load16

---
 rtl/vec_load16_pkg.sv | 25 ++
 rtl/vec_addr_gen.sv | 73 +++++++
 rtl/vec_load16.sv | 118 +++++++++++
 tb/tb_vec_load16.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_load16_pkg.sv
// -----------------------------------------------------------------------------
// vec_load16_pkg
// Shared vector-unit definitions: lane geometry, lane-index width and the
// strided-load FSM state type used by vec_load16 and its address generator.
// -----------------------------------------------------------------------------
package vec_load16_pkg;

    localparam int unsigned VEC_LANES = 16;                  // lanes per vector
    localparam int unsigned LANE_W    = 16;                  // half-precision lane
    localparam int unsigned IDX_W     = 4;                   // lane index width
    localparam int unsigned VEC_W     = VEC_LANES * LANE_W;  // packed vector width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // True when the index addresses the final lane of a vector.
    function automatic logic is_last_lane(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(VEC_LANES - 1);
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// -----------------------------------------------------------------------------
// vec_addr_gen
// Holds the captured base address and stride of a strided vector load, the
// current lane index, and the wrapping address adder producing
// base + index*stride (mod 2^ADDR_W).
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   load_i   in   capture base_i/stride_i, restart at lane 0
//   adv_i    in   advance to the next lane
//   base_i   in   ADDR_W  base word address (lane 0)
//   stride_i in   ADDR_W  two's-complement word stride
//   idx_o    out  IDX_W   current lane index
//   addr_o   out  ADDR_W  address of the current lane
// -----------------------------------------------------------------------------
module vec_addr_gen
    import vec_load16_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] base_q,   base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;

    // The offset accumulates index*stride one stride at a time, so no
    // multiplier is needed; unsigned wrap gives the modular behaviour and a
    // two's-complement stride walks downward for free.
    always_comb begin
        base_d   = base_q;
        stride_d = stride_q;
        offset_d = offset_q;
        idx_d    = idx_q;
        if (load_i) begin
            base_d   = base_i;
            stride_d = stride_i;
            offset_d = '0;
            idx_d    = '0;
        end else if (adv_i) begin
            offset_d = offset_q + stride_q;
            idx_d    = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            stride_q <= '0;
            offset_q <= '0;
            idx_q    <= '0;
        end else begin
            base_q   <= base_d;
            stride_q <= stride_d;
            offset_q <= offset_d;
            idx_q    <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = base_q + offset_q;

endmodule

// File: rtl/vec_load16.sv
// -----------------------------------------------------------------------------
// vec_load16
// Strided vector load: fetches 16 half-precision lanes from word-addressed
// memory, one read outstanding at a time, and assembles them into a 256-bit
// vector for the scalar-multiply unit.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   load request, honoured only in IDLE
//   base_addr  in   ADDR_W  word address of lane 0
//   stride     in   ADDR_W  signed word stride between lanes
//   mem_rd     out  one-cycle read strobe
//   mem_addr   out  ADDR_W  read address (zero when mem_rd is low)
//   mem_valid  in   read data valid
//   mem_rdata  in   16      read data
//   vecout     out  LANES*16  assembled vector, lane i at [16i+15:16i]
//   busy       out  load in progress
//   done       out  one-cycle pulse, vecout complete
// -----------------------------------------------------------------------------
module vec_load16
    import vec_load16_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LANES  = VEC_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    output logic                    mem_rd,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_valid,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic [LANES*LANE_W-1:0] vecout,
    output logic                    busy,
    output logic                    done
);

    state_e                  state_q, state_d;
    logic [LANES*LANE_W-1:0] vec_q,   vec_d;

    logic              ag_load;
    logic              ag_adv;
    logic [IDX_W-1:0]  lane_idx;
    logic [ADDR_W-1:0] lane_addr;

    vec_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ag_load),
        .adv_i    (ag_adv),
        .base_i   (base_addr),
        .stride_i (stride),
        .idx_o    (lane_idx),
        .addr_o   (lane_addr)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ag_load  = 1'b0;
        ag_adv   = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ag_load = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_rd   = 1'b1;
                mem_addr = lane_addr;
                busy     = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // Data is only accepted here, so stray mem_valid pulses in
                // any other state never touch the vector register.
                if (mem_valid) begin
                    vec_d[lane_idx*LANE_W +: LANE_W] = mem_rdata;
                    if (is_last_lane(lane_idx)) begin
                        state_d = DONE;
                    end else begin
                        ag_adv  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    assign vecout = vec_q;

endmodule

// File: tb/tb_vec_load16.sv
module tb_vec_load16;
    import vec_load16_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   base_addr = '0;
    logic [15:0]   stride = '0;
    logic          mem_rd;
    logic [15:0]   mem_addr;
    logic          mem_valid = 1'b0;
    logic [15:0]   mem_rdata = '0;
    logic [255:0]  vecout;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    vec_load16 #(
        .ADDR_W (16),
        .LANES  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .vecout    (vecout),
        .busy      (busy),
        .done      (done)
    );

    // Reference memory and reference vector contents
    logic [15:0] mem [0:65535];
    logic [15:0] exp_lane [16];

    int ncmp  = 0;
    int nfail = 0;

    function automatic logic [255:0] exp_vec();
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = exp_lane[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_rd"},   256'(mem_rd),   '0);
        check({tag, " mem_addr"}, 256'(mem_addr), '0);
        check({tag, " busy"},     256'(busy),     '0);
        check({tag, " done"},     256'(done),     '0);
        check({tag, " vecout"},   vecout,         '0);
    endtask

    // Idle cycles with stray mem_valid pulses: no read, no done, vector held.
    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            start     = 1'b0;
            check({tag, " idle mem_rd"}, 256'(mem_rd), '0);
            check({tag, " idle done"},   256'(done),   '0);
            check({tag, " idle busy"},   256'(busy),   '0);
            check({tag, " idle vecout"}, vecout,       exp_vec());
            mem_valid = (i % 2 == 0);
            mem_rdata = 16'($urandom);
        end
        step();
        mem_valid = 1'b0;
        check({tag, " idle vecout end"}, vecout, exp_vec());
    endtask

    // One strided load with a responding memory model. p1/p2: step numbers at
    // which an extra start pulse is driven; abort_lane >= 0 resets the DUT
    // while it waits for that lane's data.
    task automatic run_load(input logic [15:0] base, input logic [15:0] st,
                            input int lat_lo, input int lat_hi,
                            input int p1, input int p2,
                            input int abort_lane, input string tag);
        int          n, lane_req, cd, drove_lane;
        bit          finished, drove_valid, abort_pending, exp_rd, exp_done;
        logic [15:0] drove_data, ea, pend_addr;

        n = 0; lane_req = 0; cd = 0; drove_lane = 0;
        finished = 0; drove_valid = 0; abort_pending = 0;
        pend_addr = '0; drove_data = '0;
        start = 1'b1; base_addr = base; stride = st;
        mem_valid = 1'b0;

        while (!finished && n < 600) begin
            step();
            n++;
            start     = (n == p1) || (n == p2);
            base_addr = 16'($urandom);
            stride    = 16'($urandom);

            exp_rd   = (n == 1);
            exp_done = 0;
            if (drove_valid) begin
                exp_lane[drove_lane] = drove_data;
                if (drove_lane == 15) exp_done = 1;
                else exp_rd = 1;
            end
            drove_valid = 0;

            if (abort_pending) begin
                rst = 1'b1; mem_valid = 1'b0; cd = 0;
                step();
                rst = 1'b0;
                for (int i = 0; i < 16; i++) exp_lane[i] = '0;
                check_all_zero({tag, " after rst"});
                mem_valid = 1'b1;             // late response to the aborted read
                mem_rdata = 16'($urandom);
                step();
                mem_valid = 1'b0;
                check_all_zero({tag, " late valid"});
                finished = 1;
            end else begin
                check({tag, " vecout"}, vecout,         exp_vec());
                check({tag, " mem_rd"}, 256'(mem_rd),   256'(exp_rd));
                check({tag, " done"},   256'(done),     256'(exp_done));
                check({tag, " busy"},   256'(busy),     256'(!exp_done));

                mem_valid = 1'b0;
                mem_rdata = 16'($urandom);
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        mem_valid   = 1'b1;
                        mem_rdata   = mem[pend_addr];
                        drove_valid = 1;
                        drove_lane  = lane_req - 1;
                        drove_data  = mem[pend_addr];
                    end
                end
                if (mem_rd) begin
                    ea = base + 16'(lane_req) * st;
                    check({tag, " mem_addr"}, 256'(mem_addr), 256'(ea));
                    pend_addr = ea;
                    cd = $urandom_range(lat_hi, lat_lo);
                    if (lane_req == abort_lane) begin
                        cd = 3;
                        abort_pending = 1;
                    end
                    lane_req++;
                end
                if (exp_done) finished = 1;
            end
        end
        check({tag, " finished"}, 256'(finished), 256'(1));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) exp_lane[i] = '0;

        // Reset
        rst = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post reset");

        // Unit stride, single-cycle memory
        for (int k = 16'h0100; k <= 16'h010F; k++) mem[k] = 16'(16'h3C00 + k);
        run_load(16'h0100, 16'h0001, 1, 1, 0, 0, -1, "unit");
        check("unit lanes", vecout,
              {16'h3D0F, 16'h3D0E, 16'h3D0D, 16'h3D0C, 16'h3D0B, 16'h3D0A, 16'h3D09, 16'h3D08,
               16'h3D07, 16'h3D06, 16'h3D05, 16'h3D04, 16'h3D03, 16'h3D02, 16'h3D01, 16'h3D00});
        idle_check("unit", 3);

        // Address wrap at top of memory
        run_load(16'hFFFE, 16'h0001, 1, 1, 0, 0, -1, "wrap");
        idle_check("wrap", 2);

        // Negative stride, random latency
        run_load(16'($urandom), 16'hFFFF, 1, 5, 0, 0, -1, "neg");
        idle_check("neg", 2);

        // Stride zero
        run_load(16'h4321, 16'h0000, 1, 3, 0, 0, -1, "zero");
        idle_check("zero", 2);

        // Random strides and latencies
        for (int t = 0; t < 3; t++) begin
            run_load(16'($urandom), 16'($urandom), 1, 4, 0, 0, -1, "rand");
            idle_check("rand", 2);
        end

        // Start pulses while busy and in the done cycle are ignored
        run_load(16'h0800, 16'h0002, 1, 1, 5, 33, -1, "restart");
        idle_check("restart", 4);
        run_load(16'h0900, 16'h0003, 1, 2, 0, 0, -1, "after restart");
        idle_check("after restart", 2);

        // Reset while waiting on lane 7, then a clean load
        run_load(16'h1000, 16'h0005, 1, 2, 0, 0, 7, "abort");
        idle_check("abort", 2);
        run_load(16'h2000, 16'h0007, 1, 3, 0, 0, -1, "clean");
        idle_check("clean", 2);

        // All-ones (0x3C00) vector as fed to the scalar multiplier
        for (int i = 0; i < 16; i++) mem[16'(16'h3000 + 16'(i) * 16'h0003)] = 16'h3C00;
        run_load(16'h3000, 16'h0003, 1, 2, 0, 0, -1, "ones");
        check("ones lanes", vecout, {16{16'h3C00}});
        idle_check("ones", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
